tcu_ctrl_write_ep: RTL

- Write-back stage paired with the initial-EP reader in the TCU control unit.
- Consumes up to three 64-bit endpoint words that a command has modified and writes them back to the EP register file. Writes are sequential, and the block honours the register-interface stall.
- A 3-bit word mask selects which words are written; unselected words are skipped with no bus cycle.
- Sits between the command FSMs (unpriv/ext) and the register-file write port.

---
 rtl/tcu_ctrl_write_ep_if.sv | 50 +++++
 rtl/tcu_ctrl_write_ep.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tcu_ctrl_write_ep_if.sv
// EP write-back bundle: command side (start, EP words, mask,
// active/done) and register-file write port (en/addr/wdata/stall).
interface tcu_ctrl_write_ep_if #(
  parameter int TCU_EP_SIZE       = 16,
  parameter int TCU_REG_ADDR_SIZE = 32,
  parameter int TCU_REG_DATA_SIZE = 64
);
  logic                         write_ep_reg_en_o;
  logic [TCU_REG_ADDR_SIZE-1:0] write_ep_reg_addr_o;
  logic [TCU_REG_DATA_SIZE-1:0] write_ep_reg_wdata_o;
  logic                         write_ep_reg_stall_i;
  logic [TCU_EP_SIZE-1:0]       write_ep_epidx_i;
  logic [TCU_REG_DATA_SIZE-1:0] write_ep_data_0_i;
  logic [TCU_REG_DATA_SIZE-1:0] write_ep_data_1_i;
  logic [TCU_REG_DATA_SIZE-1:0] write_ep_data_2_i;
  logic [2:0]                   write_ep_mask_i;
  logic                         write_ep_start_i;
  logic                         write_ep_active_o;
  logic                         write_ep_done_o;

  modport master (
    input  write_ep_reg_en_o,
    input  write_ep_reg_addr_o,
    input  write_ep_reg_wdata_o,
    output write_ep_reg_stall_i,
    output write_ep_epidx_i,
    output write_ep_data_0_i,
    output write_ep_data_1_i,
    output write_ep_data_2_i,
    output write_ep_mask_i,
    output write_ep_start_i,
    input  write_ep_active_o,
    input  write_ep_done_o
  );

  modport slave (
    output write_ep_reg_en_o,
    output write_ep_reg_addr_o,
    output write_ep_reg_wdata_o,
    input  write_ep_reg_stall_i,
    input  write_ep_epidx_i,
    input  write_ep_data_0_i,
    input  write_ep_data_1_i,
    input  write_ep_data_2_i,
    input  write_ep_mask_i,
    input  write_ep_start_i,
    output write_ep_active_o,
    output write_ep_done_o
  );
endinterface

// File: rtl/tcu_ctrl_write_ep.sv
// Writes up to three masked EP words back to the EP register file,
// in ascending order, honouring the register-port stall.
// Ports: clk_i, reset_i (sync, active high), bus (slave side).
module tcu_ctrl_write_ep #(
  parameter int          TCU_EP_SIZE          = 16,
  parameter int          TCU_REG_ADDR_SIZE    = 32,
  parameter int          TCU_REG_DATA_SIZE    = 64,
  parameter logic [31:0] TCU_REGADDR_EP_START = 32'h0000_0040,
  parameter int          TCU_EP_REG_SIZE      = 24
) (
  input logic                clk_i,
  input logic                reset_i,
  tcu_ctrl_write_ep_if.slave bus
);

  localparam int AW = TCU_REG_ADDR_SIZE;
  localparam int DW = TCU_REG_DATA_SIZE;
  localparam int WW = AW + TCU_EP_SIZE + 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE0 = 3'd1,
    WRITE1 = 3'd2,
    WRITE2 = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t          state_q;
  state_t          idle_nxt;
  state_t          run_nxt;
  logic [2:0]      mask_q;
  logic [DW-1:0]   data_q [3];
  logic [DW-1:0]   din    [3];
  logic [AW-1:0]   base_q;
  logic [AW-1:0]   base_n;
  logic [WW-1:0]   base_w;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            done_q;
  logic            in_write;

  // Lowest selected word at or above index 'from'.
  function automatic state_t first_set(
    input logic [2:0] m,
    input logic [2:0] from
  );
    first_set = FINISH;
    for (int i = 2; i >= 0; i--) begin
      if (m[i] && (3'(i) >= from)) begin
        first_set = state_t'(3'(i + 1));
      end
    end
  endfunction

  function automatic logic [1:0] widx(input state_t s);
    widx = 2'(3'(s) - 3'd1);
  endfunction

  function automatic logic [AW-1:0] woff(input state_t s);
    woff = AW'({widx(s), 3'b000});
  endfunction

  assign din[0] = bus.write_ep_data_0_i;
  assign din[1] = bus.write_ep_data_1_i;
  assign din[2] = bus.write_ep_data_2_i;

  // Wide product so the EP index never overflows before truncation.
  assign base_w = WW'(TCU_REGADDR_EP_START)
                + WW'(bus.write_ep_epidx_i) * WW'(TCU_EP_REG_SIZE);
  assign base_n = AW'(base_w);

  assign in_write = (state_q == WRITE0) ||
                    (state_q == WRITE1) ||
                    (state_q == WRITE2);

  always_comb begin
    idle_nxt = first_set(bus.write_ep_mask_i, 3'd0);
    run_nxt  = first_set(mask_q, {1'b0, widx(state_q)} + 3'd1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      data_q  <= '{default: '0};
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.write_ep_start_i) begin
            mask_q  <= bus.write_ep_mask_i;
            data_q  <= din;
            base_q  <= base_n;
            state_q <= idle_nxt;
            done_q  <= (idle_nxt == FINISH);
            if (idle_nxt != FINISH) begin
              addr_q  <= base_n + woff(idle_nxt);
              wdata_q <= din[widx(idle_nxt)];
            end
          end
        end
        WRITE0, WRITE1, WRITE2: begin
          if (!bus.write_ep_reg_stall_i) begin
            state_q <= run_nxt;
            done_q  <= (run_nxt == FINISH);
            if (run_nxt != FINISH) begin
              addr_q  <= base_q + woff(run_nxt);
              wdata_q <= data_q[widx(run_nxt)];
            end
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.write_ep_reg_en_o    = in_write &
                                    !bus.write_ep_reg_stall_i;
  assign bus.write_ep_reg_addr_o  = addr_q;
  assign bus.write_ep_reg_wdata_o = wdata_q;
  assign bus.write_ep_active_o    = (state_q != IDLE);
  assign bus.write_ep_done_o      = done_q;

endmodule
